instr_fetch: RTL and testbench

Multi-cycle instruction fetch unit. Owns the program counter, issues word reads to instruction memory over a request/response handshake, and captures each returned word in an instruction register. It hands the instruction to the decode/controller stage over a valid/ready handshake. The register's opcode, funct3 and funct7 bit 5 fields drive the controller's decode inputs directly. Branch and jump targets return to this block as redirects.

---
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - multi-cycle instruction fetch: PC, memory request/response, instruction register
// One request outstanding at a time; redirects while a fetch is in flight drain the stale response.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemReqReady,
  input  logic        i_imemRspValid,
  input  logic [31:0] i_imemRspData,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  output logic [31:0] o_instr,
  output logic [6:0]  o_operand,
  output logic [2:0]  o_funct3,
  output logic        o_funct7bit5,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_redirect_lsbs;

  // Targets are word aligned; the low bits of the redirect address are dropped.
  assign target               = {i_redirectPc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^i_redirectPc[1:0];
  assign pc_plus4             = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (i_redirect) pc_d = target;
        if (i_imemReqReady) state_d = i_redirect ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_redirect) begin
          pc_d    = target;
          state_d = i_imemRspValid ? ST_REQ : ST_DRAIN;
        end else if (i_imemRspValid) begin
          instr_d = i_imemRspData;
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The in-flight response belongs to an abandoned PC and is thrown away.
        if (i_redirect) pc_d = target;
        if (i_imemRspValid) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (i_instrReady) begin
          pc_d    = i_redirect ? target : pc_plus4;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign o_imemReq    = (state_q == ST_REQ);
  assign o_instrValid = (state_q == ST_HOLD);
  assign o_imemAddr   = pc_q;
  assign o_pc         = pc_q;
  assign o_pcPlus4    = pc_plus4;
  assign o_instr      = instr_q;
  assign o_operand    = instr_q[6:0];
  assign o_funct3     = instr_q[14:12];
  assign o_funct7bit5 = instr_q[30];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - bench for instr_fetch: reactive memory, flag-level model, directed scenarios
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  operand;
  logic [2:0]  funct3;
  logic        funct7bit5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cfg_lat   = 1;
  int cfg_stall = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imemReq(imem_req), .o_imemAddr(imem_addr), .i_imemReqReady(imem_req_ready),
    .i_imemRspValid(imem_rsp_valid), .i_imemRspData(imem_rsp_data),
    .o_instrValid(instr_valid), .i_instrReady(instr_ready), .o_instr(instr),
    .o_operand(operand), .o_funct3(funct3), .o_funct7bit5(funct7bit5),
    .o_pc(pc), .o_pcPlus4(pc_plus4),
    .i_redirect(redirect), .i_redirectPc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0020_81B3;
    return {a[15:0], a[15:0] ^ 16'hC3A5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_sig(input bit want_valid, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (want_valid ? (instr_valid === 1'b1) : (imem_req === 1'b1)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s: got no event expected one within 60 cycles", name);
    end
  endtask

  task automatic next_neg();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  // Memory: ready after cfg_stall cycles of each request, response cfg_lat cycles after acceptance.
  initial begin
    bit          acc, pend, prev_req;
    int          pend_cnt, stall_left;
    logic [31:0] acc_addr, pend_addr;
    pend = 1'b0; prev_req = 1'b0; pend_cnt = 0; stall_left = 0;
    acc_addr = '0; pend_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      acc      = (imem_req === 1'b1) && imem_req_ready;
      acc_addr = imem_addr;
      @(posedge clk); #1;
      if (acc) begin pend = 1'b1; pend_cnt = cfg_lat; pend_addr = acc_addr; end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hBAD0_0000 ^ $urandom_range(0, 255);
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end
      end
      if (imem_req === 1'b1 && !prev_req) stall_left = cfg_stall;
      if (imem_req === 1'b1) begin
        imem_req_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else imem_req_ready = 1'b0;
      prev_req = (imem_req === 1'b1);
    end
  end

  // Model: tracks "starting", "fetch outstanding", "fetch stale", "holding" and the architectural PC.
  initial begin
    bit          m_known, m_start, m_out, m_stale, m_hold;
    logic [31:0] m_pc, m_instr, tgt;
    m_known = 0; m_start = 0; m_out = 0; m_stale = 0; m_hold = 0;
    m_pc = '0; m_instr = '0;
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("m_req", {31'b0, imem_req}, {31'b0, !m_start && !m_out && !m_hold});
        chk("m_valid", {31'b0, instr_valid}, {31'b0, m_hold});
        if (!m_start && !m_out && !m_hold) chk("m_addr", imem_addr, m_pc);
        chk("m_pc", pc, m_pc);
        chk("m_pc4", pc_plus4, m_pc + 32'd4);
        chk("m_instr", instr, m_instr);
        chk("m_opcode", {25'b0, operand}, {25'b0, m_instr[6:0]});
        chk("m_funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
        chk("m_f7b5", {31'b0, funct7bit5}, {31'b0, m_instr[30]});
      end
      tgt = redirect_pc & 32'hFFFF_FFFC;
      if (rst) begin
        m_known = 1; m_start = 1; m_out = 0; m_stale = 0; m_hold = 0;
        m_pc = 32'h0; m_instr = 32'h0;
      end else if (m_start) begin
        m_start = 0;
      end else if (m_hold) begin
        if (instr_ready) begin
          m_hold = 0;
          m_pc   = redirect ? tgt : m_pc + 32'd4;
        end
      end else if (!m_out) begin
        if (redirect) m_pc = tgt;
        if (imem_req_ready) begin m_out = 1; m_stale = redirect; end
      end else begin
        if (redirect) begin m_pc = tgt; m_stale = 1; end
        if (imem_rsp_valid) begin
          m_out = 0;
          if (!m_stale) begin m_hold = 1; m_instr = imem_rsp_data; end
          m_stale = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rec_req[11];
    bit          rec_valid[11];
    logic [31:0] rec_addr[11];
    logic [31:0] a0;
    bit          found;
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Sequential zero-wait fetch: one instruction every 3 cycles.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      rec_req[k] = imem_req; rec_valid[k] = instr_valid; rec_addr[k] = imem_addr;
      @(posedge clk); #1;
    end
    instr_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk("seq_req", {31'b0, rec_req[k]}, {31'b0, k % 3 == 1});
      chk("seq_valid", {31'b0, rec_valid[k]}, {31'b0, k % 3 == 0 && k > 0});
      if (k % 3 == 1) chk("seq_addr", rec_addr[k], (k - 1) / 3 * 4);
    end

    // Decode backpressure on 0x002081B3.
    wait_sig(1'b1, "bp_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_neg();
      chk("bp_instr", instr, 32'h0020_81B3);
      chk("bp_opcode", {25'b0, operand}, 32'h33);
      chk("bp_funct3", {29'b0, funct3}, 32'h0);
      chk("bp_f7b5", {31'b0, funct7bit5}, 32'h0);
      chk("bp_noreq", {31'b0, imem_req}, 32'h0);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_cycle_req", {31'b0, imem_req}, 32'h0);
    next_neg();
    chk("bp_next_req", {31'b0, imem_req}, 32'h1);
    chk("bp_next_addr", imem_addr, 32'h10);

    // Redirect in WAIT together with the response.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b0;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("wrsp_addr", imem_addr, 32'h100);
    wait_sig(1'b1, "hold_valid");
    chk("hold_pc", pc, 32'h100);
    chk("hold_instr", instr, mem_word(32'h100));

    // Redirect in HOLD: ignored without ready, taken with ready.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h999;
    @(negedge clk);
    chk("hold_ignore_pc", pc, 32'h100);
    @(posedge clk); #1 redirect_pc = 32'h203; instr_ready = 1'b1; cfg_lat = 3;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("hold_redir_addr", imem_addr, 32'h200);

    // Redirect in WAIT with 3-cycle latency: stale response drained.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1 redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) found = 1'b1;
      else begin
        chk("drain_valid_low", {31'b0, instr_valid}, 32'h0);
        @(posedge clk); #1;
      end
    end
    chk("drain_req_seen", {31'b0, found}, 32'h1);
    chk("drain_addr", imem_addr, 32'h300);
    wait_sig(1'b1, "drain_valid");
    chk("drain_pc", pc, 32'h300);
    chk("drain_instr", instr, mem_word(32'h300));
    cfg_stall = 4; cfg_lat = 1;

    // Memory stall: request held four cycles, accepted in the fifth.
    wait_sig(1'b0, "stall_req");
    a0 = imem_addr;
    chk("stall_addr", a0, 32'h304);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_neg();
      chk("stall_req_held", {31'b0, imem_req}, 32'h1);
      chk("stall_addr_held", imem_addr, a0);
    end
    next_neg();
    chk("stall_accepted", {31'b0, imem_req}, 32'h0);

    // Redirect during a stalled request, then wrap past the top of memory.
    wait_sig(1'b0, "stall2_req");
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("stall2_addr_old", imem_addr, 32'h308);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("stall2_addr_new", imem_addr, 32'hFFFF_FFFC);
    cfg_stall = 0;
    wait_sig(1'b1, "wrap_valid");
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    cfg_lat = 3;
    next_neg();
    chk("wrap_req", {31'b0, imem_req}, 32'h1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while waiting on the response; the late response must be ignored.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {25'b0, operand}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    wait_sig(1'b1, "rst_refetch");
    chk("rst_refetch_pc", pc, 32'h0);
    chk("rst_refetch_instr", instr, mem_word(32'h0));

    // Redirect on the cycle a request is accepted.
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1 redirect = 1'b0;
    wait_sig(1'b1, "reqacc_valid");
    chk("reqacc_pc", pc, 32'h40);
    chk("reqacc_instr", instr, mem_word(32'h40));

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
